// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the enemy-car fleet mover.
//   car_type_t   : kind of enemy car held by a slot
//   slot_state_t : per-slot motion FSM states
//   car_speed()  : per-type vertical speed in pixels per motion update
//   INIT_Y       : off-screen start row for a freshly released car (-OBJ_H)
package traffic_pkg;

    typedef enum logic [1:0] {
        YELLOW     = 2'd0,
        RED        = 2'd1,
        BLUE_TRUCK = 2'd2,
        STABLE     = 2'd3
    } car_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2
    } slot_state_t;

    localparam int               OBJ_H_DEF = 32;
    localparam logic signed [10:0] INIT_Y  = 11'(-OBJ_H_DEF);

    // Speeds are identical today but kept per type so they can diverge.
    function automatic logic [3:0] car_speed(input car_type_t t);
        case (t)
            YELLOW:     return 4'd3;
            RED:        return 4'd3;
            BLUE_TRUCK: return 4'd3;
            STABLE:     return 4'd3;
            default:    return 4'd3;
        endcase
    endfunction

endpackage

// File: rtl/car_slot.sv
// car_slot: one enemy-car slot (FSM, position, steering).
//   clk, reset      : clock, async active-high reset
//   grant           : load a new car (honoured only while IDLE)
//   move_tick       : motion update strobe
//   steer_win       : steering enabled for RED cars this update
//   freeze / flush  : hold everything / retire immediately
//   playerspeed     : player speed added to Y each update
//   ld_type/ld_x/ld_target : release data loaded on grant
//   idle, active    : slot state flags
//   x, y, ctype     : current position and car type
module car_slot
    import traffic_pkg::*;
#(
    parameter int OBJ_H    = OBJ_H_DEF,
    parameter int Y_BOTTOM = 479,
    parameter int X_STEP   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               grant,
    input  logic               move_tick,
    input  logic               steer_win,
    input  logic               freeze,
    input  logic               flush,
    input  logic [3:0]         playerspeed,
    input  car_type_t          ld_type,
    input  logic [10:0]        ld_x,
    input  logic [10:0]        ld_target,
    output logic               idle,
    output logic               active,
    output logic signed [10:0] x,
    output logic signed [10:0] y,
    output car_type_t          ctype
);

    localparam logic signed [10:0] L_INIT_Y = 11'(-OBJ_H);

    slot_state_t        r_state, w_state_nx;
    logic signed [10:0] r_x, r_y, r_target;
    logic signed [10:0] w_x_nx, w_y_nx, w_target_nx;
    car_type_t          r_type, w_type_nx;

    logic signed [11:0] w_y_step;   // Y after one update, before truncation
    logic signed [11:0] w_y_bottom; // bottom edge of the car
    logic signed [11:0] w_dx;       // signed distance to steering target
    logic               w_offscreen;

    always_comb begin
        w_y_step    = $signed({r_y[10], r_y}) - $signed({8'd0, car_speed(r_type)})
                    + $signed({8'd0, playerspeed});
        w_y_bottom  = $signed({r_y[10], r_y}) + $signed(12'(OBJ_H));
        w_dx        = $signed({r_target[10], r_target}) - $signed({r_x[10], r_x});
        w_offscreen = (w_y_bottom < 0) || (r_y > $signed(11'(Y_BOTTOM)));
    end

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx  = r_state;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_type_nx   = r_type;
        w_target_nx = r_target;

        if (flush) begin
            w_state_nx = IDLE;
        end else if (grant && r_state == IDLE) begin
            // Grants bypass freeze: they only touch a slot that is not moving.
            w_state_nx  = MOVE;
            w_x_nx      = ld_x;
            w_y_nx      = L_INIT_Y;
            w_type_nx   = ld_type;
            w_target_nx = ld_target;
        end else if (!freeze) begin
            case (r_state)
                MOVE: begin
                    if (move_tick) begin
                        w_state_nx = CHECK;
                        w_y_nx     = w_y_step[10:0];
                        if (r_type == RED && steer_win) begin
                            // Clamp to the target so the step never overshoots.
                            if (w_dx > $signed(12'(X_STEP)))
                                w_x_nx = r_x + 11'(X_STEP);
                            else if (w_dx < -$signed(12'(X_STEP)))
                                w_x_nx = r_x - 11'(X_STEP);
                            else
                                w_x_nx = r_target;
                        end
                    end
                end
                CHECK:   w_state_nx = w_offscreen ? IDLE : MOVE;
                default: w_state_nx = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= L_INIT_Y;
            r_type   <= YELLOW;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_type   <= w_type_nx;
            r_target <= w_target_nx;
        end
    end

    assign idle   = (r_state == IDLE);
    assign active = (r_state != IDLE);
    assign x      = r_x;
    assign y      = r_y;
    assign ctype  = r_type;

endmodule

// File: rtl/traffic_fleet_move.sv
// traffic_fleet_move: NUM_CARS enemy-car slots with shared release allocator.
//   clk, reset        : clock, async active-high reset
//   startOfFrame      : frame pulse; onesec : one-second pulse
//   playerspeed       : player speed added to every car's Y per update
//   freeze, flush     : pause all motion / retire all slots
//   release_*         : spawn request and car data (sampled on startOfFrame)
//   ready             : some slot is IDLE
//   release_ack/slot  : registered grant pulse and granted slot index
//   release_drop      : registered pulse, request rejected (fleet full)
//   active, topLeftX, topLeftY, carType : flattened per-slot outputs
module traffic_fleet_move
    import traffic_pkg::*;
#(
    parameter int NUM_CARS     = 4,
    parameter int FRAME_DIV    = 4,
    parameter int STEER_PERIOD = 4,
    parameter int X_STEP       = 1,
    parameter int OBJ_H        = OBJ_H_DEF,
    parameter int Y_BOTTOM     = 479,
    localparam int SLOT_W      = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  onesec,
    input  logic [3:0]            playerspeed,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  release_req,
    input  logic [1:0]            release_type,
    input  logic [10:0]           release_x,
    input  logic [10:0]           release_target_x,
    output logic                  ready,
    output logic                  release_ack,
    output logic [SLOT_W-1:0]     release_slot,
    output logic                  release_drop,
    output logic [NUM_CARS-1:0]   active,
    output logic [11*NUM_CARS-1:0] topLeftX,
    output logic [11*NUM_CARS-1:0] topLeftY,
    output logic [2*NUM_CARS-1:0] carType
);

    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SC_W = (STEER_PERIOD > 1) ? $clog2(STEER_PERIOD) : 1;

    logic [FC_W-1:0]   r_frame_cnt;
    logic [SC_W-1:0]   r_sec_cnt;
    logic              r_ack, r_drop;
    logic [SLOT_W-1:0] r_slot;

    logic                w_move_tick, w_steer_win, w_req, w_found;
    logic [SLOT_W-1:0]   w_idx;
    logic [NUM_CARS-1:0] w_grant, w_idle, w_active;
    logic signed [10:0]  w_x [NUM_CARS];
    logic signed [10:0]  w_y [NUM_CARS];
    car_type_t           w_type [NUM_CARS];

    assign w_move_tick = startOfFrame && (r_frame_cnt == '0);
    assign w_steer_win = (r_sec_cnt == '0);
    assign w_req       = startOfFrame && release_req && !flush;

    // Lowest-index IDLE slot wins. Uses registered state, so a slot retiring
    // on this same edge is not eligible until the next frame.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (w_idle[i] && !w_found) begin
                w_found    = 1'b1;
                w_idx      = SLOT_W'(i);
                w_grant[i] = w_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_sec_cnt   <= '0;
            r_ack       <= 1'b0;
            r_drop      <= 1'b0;
            r_slot      <= '0;
        end else begin
            if (startOfFrame)
                r_frame_cnt <= (r_frame_cnt == FC_W'(FRAME_DIV - 1)) ? '0 : r_frame_cnt + 1'b1;
            if (onesec)
                r_sec_cnt <= (r_sec_cnt == SC_W'(STEER_PERIOD - 1)) ? '0 : r_sec_cnt + 1'b1;
            r_ack  <= w_req && w_found;
            r_drop <= w_req && !w_found;
            r_slot <= w_idx;
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_slot
        car_slot #(
            .OBJ_H    (OBJ_H),
            .Y_BOTTOM (Y_BOTTOM),
            .X_STEP   (X_STEP)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .grant       (w_grant[g]),
            .move_tick   (w_move_tick),
            .steer_win   (w_steer_win),
            .freeze      (freeze),
            .flush       (flush),
            .playerspeed (playerspeed),
            .ld_type     (car_type_t'(release_type)),
            .ld_x        (release_x),
            .ld_target   (release_target_x),
            .idle        (w_idle[g]),
            .active      (w_active[g]),
            .x           (w_x[g]),
            .y           (w_y[g]),
            .ctype       (w_type[g])
        );
        assign topLeftX[11*g +: 11] = w_x[g];
        assign topLeftY[11*g +: 11] = w_y[g];
        assign carType[2*g +: 2]    = w_type[g];
    end

    assign ready        = |w_idle;
    assign active       = w_active;
    assign release_ack  = r_ack;
    assign release_drop = r_drop;
    assign release_slot = r_slot;

endmodule

// File: doc/traffic_fleet_move.md
Name: traffic_fleet_move

Overview:
- Parametrised successor of the single-car mover: one block owns NUM_CARS independent enemy-car slots.
- Each slot runs its own per-frame vertical motion relative to the player's speed, with optional horizontal steering toward a target lane.
- A shared release interface allocates new cars to free slots; a slot retires when its car leaves the screen.
- Sits between the spawn/random logic and the per-car bitmap/draw and collision blocks of the VGA game.

Parameters:
- NUM_CARS, 4, number of car slots (1..8).
- FRAME_DIV, 4, motion update happens on one startOfFrame out of every FRAME_DIV.
- STEER_PERIOD, 4, steering is enabled only when the onesec count modulo STEER_PERIOD equals 0.
- X_STEP, 1, steering pixels per motion update.
- OBJ_H, 32, car height in pixels.
- Y_BOTTOM, 479, last visible row.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  single-cycle pulse at frame start.
- onesec  in  1  single-cycle pulse once per second.
- playerspeed  in  4  unsigned player speed, pixels per update.
- freeze  in  1  holds all positions and FSMs (pause screen).
- flush  in  1  synchronous retire of all slots.
- release_req  in  1  spawn request, sampled only on startOfFrame.
- release_type  in  2  car type (car_type_t).
- release_x  in  11  initial X.
- release_target_x  in  11  steering target X (used by RED only).
- ready  out  1  at least one slot is IDLE.
- release_ack  out  1  one-cycle pulse: request accepted.
- release_slot  out  $clog2(NUM_CARS) (min 1)  slot index granted, valid with release_ack.
- release_drop  out  1  one-cycle pulse: request rejected because all slots are busy.
- active  out  NUM_CARS  per-slot MOVE/CHECK flag.
- topLeftX  out  11*NUM_CARS  signed X per slot, slot i at [11i+10:11i].
- topLeftY  out  11*NUM_CARS  signed Y per slot.
- carType  out  2*NUM_CARS  type held by each slot.

Behaviour:
- Reset (async, reset=1): all slots IDLE, X=0, Y=-OBJ_H, type=YELLOW, active=0, frame and onesec counters=0, all pulse outputs=0.
- Counters:
  - frame_cnt increments mod FRAME_DIV on each startOfFrame; move_tick = startOfFrame && frame_cnt==0.
  - sec_cnt increments mod STEER_PERIOD on each onesec; steer_win = (sec_cnt==0).
- Slot FSM states IDLE, MOVE, CHECK:
  - IDLE -> MOVE on grant. Load X=release_x, Y=-OBJ_H, type, target.
  - MOVE -> CHECK on move_tick.
    - Y <= Y - speed(type) + playerspeed, computed as 12-bit signed then truncated to 11.
    - If type==RED and steer_win: X steps toward target by X_STEP, clamped to target (no overshoot); X is unchanged when equal.
  - CHECK lasts exactly one cycle.
    - Y+OBJ_H < 0, or Y > Y_BOTTOM -> IDLE (active drops the same edge).
    - Otherwise -> MOVE.
- Speed LUT: YELLOW 3, RED 3, BLUE_TRUCK 3, STABLE 3. Kept per-type so they can diverge.
- Allocation:
  - On startOfFrame && release_req, the lowest-index slot currently IDLE (registered state) is granted.
  - release_ack and release_slot are registered and valid the next cycle.
  - If no slot is IDLE, release_drop pulses instead.
  - Only one grant per frame.
- Simultaneous events:
  - A slot leaving CHECK->IDLE on the same edge as a release is not eligible that frame.
  - A release on a move_tick grants the slot, but the first move happens on the next move_tick.
- freeze=1: all FSMs and positions hold. Counters still run. Releases are still granted, since the grant affects only IDLE slots.
- flush=1: all slots go to IDLE on the next edge. It overrides release and freeze; no ack is given that cycle.
- Reset mid-motion: immediate return to reset values. No pulse survives.

Decomposition:
- Package traffic_pkg holds:
  - car_type_t enum {YELLOW, RED, BLUE_TRUCK, STABLE}.
  - slot_state_t enum {IDLE, MOVE, CHECK}.
  - function car_speed(car_type_t).
  - constant INIT_Y = -OBJ_H.
- Sub-module car_slot holds one slot's FSM, position, and steering.
  - traffic_fleet_move instantiates NUM_CARS of them via generate.
  - It owns the counters, priority allocator, and output flattening.

Test Plan:
- After reset, release YELLOW x=200 on frame 0, playerspeed=5 -> ack next cycle, slot 0. At the next move_tick Y goes -32 -> -30. X stays 200.
- YELLOW with playerspeed=0 -> first move gives Y=-35, CHECK sees -3<0 and the slot returns to IDLE. active[0] drops and ready=1.
- YELLOW with playerspeed=15 (net +12 per move) -> retires after 43 moves at Y=484. Y=472 at move 42 stays active.
- RED x=200, target=202, steer_win held -> X = 201, 202, 202 over three moves. Target=198 from X=200 -> 199, 198, 198.
- NUM_CARS=4, release on 5 consecutive frames with no retirements -> acks with slots 0, 1, 2, 3, then release_drop on frame 5. ready=0 after the 4th grant.
- Slot 1 retires in the same cycle as a release while slot 0 is busy -> grant goes to slot 2, not slot 1. flush during MOVE -> all active=0 next cycle. Asserting reset mid-move -> Y=-32 immediately.
